// File: rtl/aud_recorder.sv
// I2S left-channel capture: deserialises 16-bit left samples on the bit clock and
// writes each one to sample memory with a single-cycle strobe under start/pause/stop control.
module aud_recorder #(
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              i_bclk,
    input  logic              i_rst_n,
    input  logic              i_adclrck,
    input  logic              i_adcdat,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    output logic [ADDR_W-1:0] o_address,
    output logic [15:0]       o_data,
    output logic              o_we,
    output logic [ADDR_W:0]   o_len,
    output logic              o_busy,
    output logic              o_full
);

    // state   | meaning
    // S_IDLE  | not recording; o_len/o_data/o_full hold last result
    // S_ARM   | wait for right half so capture starts on a fresh left frame
    // S_WAIT  | wait for LRCK low; that edge is the I2S delay slot
    // S_SHIFT | shifting 16 left-channel bits, MSB first
    // S_WRITE | write strobe high; decide full/stop/pause/continue
    // S_PAUSE | paused between words, o_address held
    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WAIT, S_SHIFT, S_WRITE, S_PAUSE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;
    logic [15:0]       data_q, data_d;
    logic              we_q, we_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              full_q, full_d;
    logic [14:0]       shift_q, shift_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ppend_q, ppend_d;

    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            oaddr_q <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            len_q   <= '0;
            full_q  <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
            ppend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            oaddr_q <= oaddr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            len_q   <= len_d;
            full_q  <= full_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ppend_q <= ppend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        oaddr_d = oaddr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        len_d   = len_q;
        full_d  = full_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        ppend_d = ppend_q;
        case (state_q)
            S_IDLE: begin
                if (i_start && !i_stop) begin
                    addr_d  = '0;
                    len_d   = '0;
                    full_d  = 1'b0;
                    ppend_d = 1'b0;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (i_stop)         state_d = S_IDLE;
                else if (i_pause)   state_d = S_PAUSE;
                else if (i_adclrck) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_stop)       state_d = S_IDLE;
                else if (i_pause) state_d = S_PAUSE;
                else if (!i_adclrck) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (i_stop) begin
                    ppend_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    shift_d = {shift_q[13:0], i_adcdat};
                    cnt_d   = cnt_q + 4'd1;
                    if (i_pause) ppend_d = 1'b1;
                    if (cnt_q == 4'd15) begin
                        data_d  = {shift_q, i_adcdat};
                        oaddr_d = addr_q;
                        we_d    = 1'b1;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                len_d   = len_q + 1'b1;
                ppend_d = 1'b0;
                // Full check comes first so the address never wraps.
                if (addr_q == MAX_ADDR) begin
                    full_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_pause || ppend_q) begin
                    state_d = S_PAUSE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_ARM;
                end
            end
            S_PAUSE: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_start && !i_pause) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_ARM;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_address = oaddr_q;
    assign o_data    = data_q;
    assign o_we      = we_q;
    assign o_len     = len_q;
    assign o_busy    = (state_q != S_IDLE);
    assign o_full    = full_q;

endmodule

// File: tb/tb_aud_recorder.sv
// Directed bench for aud_recorder: drives I2S frames (20 bclk per half-frame)
// and checks writes, lengths and control flags against hand-computed values.
module tb_aud_recorder;
    localparam int ADDR_W = 20;
    localparam int HALF   = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              lrck = 1'b1;
    logic              dat = 1'b0;
    logic              start = 1'b0;
    logic              pause = 1'b0;
    logic              stop = 1'b0;
    logic [ADDR_W-1:0] o_address;
    logic [15:0]       o_data;
    logic              o_we;
    logic [ADDR_W:0]   o_len;
    logic              o_busy;
    logic              o_full;

    int total = 0;
    int bad   = 0;
    logic [ADDR_W-1:0] wa[$];
    logic [15:0]       wd[$];

    aud_recorder #(.ADDR_W(ADDR_W), .MAX_ADDR(20'd3)) dut (
        .i_bclk(clk), .i_rst_n(rst_n), .i_adclrck(lrck), .i_adcdat(dat),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .o_address(o_address), .o_data(o_data), .o_we(o_we), .o_len(o_len),
        .o_busy(o_busy), .o_full(o_full)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_we === 1'b1) begin
            wa.push_back(o_address);
            wd.push_back(o_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic clear_writes();
        wa.delete();
        wd.delete();
    endtask

    // Slot 0 of each half is the I2S delay slot; slots 1..16 carry MSB..LSB.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int pause_slot, input int stop_slot,
                              input int rst_slot, input int start_slot, input bit lat);
        for (int s = 0; s < HALF; s++) begin
            @(negedge clk);
            lrck  = 1'b0;
            dat   = (s >= 1 && s <= 16) ? l[16-s] : 1'b0;
            pause = (s == pause_slot);
            stop  = (s == stop_slot);
            start = (s == start_slot);
            rst_n = (s != rst_slot);
            if (lat && (s == 16 || s == 17)) begin
                @(posedge clk); #1;
                if (s == 16) begin
                    chk("lat_we_hi", 32'(o_we), 32'd1);
                    chk("lat_data", 32'(o_data), 32'(l));
                    chk("lat_addr", 32'(o_address), 32'd0);
                end else begin
                    chk("lat_we_lo", 32'(o_we), 32'd0);
                    chk("lat_len", 32'(o_len), 32'd1);
                end
            end
        end
        for (int s = 0; s < HALF; s++) begin
            @(negedge clk);
            lrck  = 1'b1;
            dat   = (s >= 1 && s <= 16) ? r[16-s] : 1'b0;
            pause = 1'b0;
            stop  = 1'b0;
            start = 1'b0;
            rst_n = 1'b1;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_addr", 32'(o_address), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_we", 32'(o_we), 32'd0);
        chk("rst_len", 32'(o_len), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_full", 32'(o_full), 32'd0);

        // Single left word, right word ignored, strobe latency
        pulse_start();
        chk("t1_busy", 32'(o_busy), 32'd1);
        send_frame(16'hA5C3, 16'hFFFF, -1, -1, -1, -1, 1'b1);
        pulse_stop();
        chk("t1_nw", 32'(wd.size()), 32'd1);
        chk("t1_d0", 32'(wd[0]), 32'hA5C3);
        chk("t1_a0", 32'(wa[0]), 32'd0);
        chk("t1_busy_end", 32'(o_busy), 32'd0);
        clear_writes();

        // Three consecutive frames, then stop
        pulse_start();
        send_frame(16'h0001, 16'h0000, -1, -1, -1, -1, 1'b0);
        send_frame(16'h8000, 16'hFFFF, -1, -1, -1, -1, 1'b0);
        send_frame(16'h7FFF, 16'h5555, -1, -1, -1, -1, 1'b0);
        pulse_stop();
        chk("t2_nw", 32'(wd.size()), 32'd3);
        chk("t2_d0", 32'(wd[0]), 32'h0001);
        chk("t2_d1", 32'(wd[1]), 32'h8000);
        chk("t2_d2", 32'(wd[2]), 32'h7FFF);
        chk("t2_a1", 32'(wa[1]), 32'd1);
        chk("t2_a2", 32'(wa[2]), 32'd2);
        chk("t2_len", 32'(o_len), 32'd3);
        chk("t2_busy", 32'(o_busy), 32'd0);
        clear_writes();

        // Pause during bit 7 (slot 9), resume after four frames
        pulse_start();
        send_frame(16'h1234, 16'h0000, 9, -1, -1, -1, 1'b0);
        chk("t3_nw_a", 32'(wd.size()), 32'd1);
        chk("t3_d0", 32'(wd[0]), 32'h1234);
        for (int f = 0; f < 4; f++) send_frame(16'hBEEF, 16'h0000, -1, -1, -1, -1, 1'b0);
        chk("t3_nw_paused", 32'(wd.size()), 32'd1);
        chk("t3_busy_paused", 32'(o_busy), 32'd1);
        chk("t3_addr_held", 32'(o_address), 32'd0);
        pulse_start();
        send_frame(16'h5678, 16'h0000, -1, -1, -1, -1, 1'b0);
        pulse_stop();
        chk("t3_nw", 32'(wd.size()), 32'd2);
        chk("t3_d1", 32'(wd[1]), 32'h5678);
        chk("t3_a1", 32'(wa[1]), 32'd1);
        chk("t3_len", 32'(o_len), 32'd2);
        clear_writes();

        // MAX_ADDR = 3: five frames give four writes then full
        pulse_start();
        send_frame(16'h1000, 16'h0000, -1, -1, -1, -1, 1'b0);
        send_frame(16'h2001, 16'h0000, -1, -1, -1, -1, 1'b0);
        send_frame(16'h3002, 16'h0000, -1, -1, -1, -1, 1'b0);
        send_frame(16'h4003, 16'h0000, -1, -1, -1, -1, 1'b0);
        send_frame(16'h5004, 16'h0000, -1, -1, -1, -1, 1'b0);
        chk("t4_nw", 32'(wd.size()), 32'd4);
        chk("t4_a3", 32'(wa[3]), 32'd3);
        chk("t4_d3", 32'(wd[3]), 32'h4003);
        chk("t4_full", 32'(o_full), 32'd1);
        chk("t4_len", 32'(o_len), 32'd4);
        chk("t4_busy", 32'(o_busy), 32'd0);
        clear_writes();
        pulse_start();
        chk("t4_full_clr", 32'(o_full), 32'd0);
        chk("t4_len_clr", 32'(o_len), 32'd0);
        send_frame(16'h0BAD, 16'h0000, -1, -1, -1, -1, 1'b0);
        pulse_stop();
        chk("t4_restart_nw", 32'(wd.size()), 32'd1);
        chk("t4_restart_a", 32'(wa[0]), 32'd0);
        chk("t4_restart_d", 32'(wd[0]), 32'h0BAD);
        clear_writes();

        // Stop at bit 10 (slot 6) drops the partial word
        pulse_start();
        send_frame(16'h4444, 16'h0000, -1, -1, -1, -1, 1'b0);
        send_frame(16'h5555, 16'h0000, -1, 6, -1, -1, 1'b0);
        chk("t5_nw", 32'(wd.size()), 32'd1);
        chk("t5_len", 32'(o_len), 32'd1);
        chk("t5_busy", 32'(o_busy), 32'd0);
        clear_writes();

        // Reset at bit 10 discards the word and clears everything
        pulse_start();
        send_frame(16'h6666, 16'h0000, -1, -1, 6, -1, 1'b0);
        chk("t5r_nw", 32'(wd.size()), 32'd0);
        chk("t5r_addr", 32'(o_address), 32'd0);
        chk("t5r_data", 32'(o_data), 32'd0);
        chk("t5r_len", 32'(o_len), 32'd0);
        chk("t5r_busy", 32'(o_busy), 32'd0);
        chk("t5r_full", 32'(o_full), 32'd0);
        clear_writes();

        // Start mid-left-frame: that frame is skipped
        send_frame(16'h1111, 16'h0000, -1, -1, -1, 5, 1'b0);
        chk("t6_busy", 32'(o_busy), 32'd1);
        send_frame(16'h2222, 16'h0000, -1, -1, -1, -1, 1'b0);
        pulse_stop();
        chk("t6_nw", 32'(wd.size()), 32'd1);
        chk("t6_d0", 32'(wd[0]), 32'h2222);
        chk("t6_a0", 32'(wa[0]), 32'd0);
        chk("t6_len", 32'(o_len), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
